// File: rtl/uart_tx_fifo.sv
// Circular TX FIFO plus frame launcher: pops a word onto tx_data, strobes tx_start low, waits for tx_done.
// Latency: write into an idle, empty block reaches tx_data/tx_start one cycle later; writes while full are dropped (sticky overflow).
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  tx_clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  ovf_clr,
    input  logic                  tx_done,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_start,
    output logic                  busy
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  pop;
    logic                  wr_acc;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    // Acceptance looks only at the registered full flag, so a same-cycle pop never frees a slot early.
    assign wr_acc   = wr_en && !full;
    assign tx_start = (state_q != START);
    assign busy     = (state_q == START) || (state_q == WAIT);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (tx_done) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge tx_clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tx_data  <= '0;
        end else begin
            state_q <= state_d;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                tx_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({wr_acc, pop})
                2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, single frame, back-to-back, wrap, fill/overflow and corner cases.
module tb_uart_tx_fifo;

    logic       tx_clk;
    logic       resetn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ovf_clr;
    logic       tx_done;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    uart_tx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .tx_clk   (tx_clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ovf_clr  (ovf_clr),
        .tx_done  (tx_done),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .busy     (busy)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Writes n words base.. as space allows and answers each tx_start with tx_done gap cycles later.
    task automatic stream(input int n, input logic [7:0] base, input int gap);
        int wr_i      = 0;
        int fr        = 0;
        int cyc       = 0;
        int done_at   = -1;
        int last_done = -1;
        bit busy_gap  = 1'b0;
        while ((fr < n || cyc < done_at) && cyc < 3000) begin
            @(negedge tx_clk);
            cyc++;
            if (fr > 0 && !busy) busy_gap = 1'b1;
            if (!tx_start) begin
                chk("frame_dat", 32'(tx_data), 32'(base) + 32'(fr));
                if (fr > 0) chk("b2b_gap", 32'(cyc - last_done), 32'd1);
                fr++;
                done_at = cyc + gap;
            end
            tx_done = (cyc == done_at);
            if (tx_done) last_done = cyc;
            wr_en   = (wr_i < n) && !full;
            wr_data = base + 8'(wr_i);
            if (wr_en) wr_i++;
        end
        @(negedge tx_clk);
        wr_en   = 1'b0;
        tx_done = 1'b0;
        chk("frame_cnt", 32'(fr), 32'(n));
        chk("busy_gap", 32'(busy_gap), 32'd0);
        @(negedge tx_clk);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        resetn  = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ovf_clr = 1'b0;
        tx_done = 1'b0;
        repeat (2) @(negedge tx_clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        resetn = 1'b1;

        // Single byte
        @(negedge tx_clk);
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        @(negedge tx_clk);
        wr_en = 1'b0;
        chk("sb_e0_count", 32'(count), 32'd1);
        chk("sb_e0_start", 32'(tx_start), 32'd1);
        chk("sb_e0_busy", 32'(busy), 32'd0);
        @(negedge tx_clk);
        chk("sb_e1_data", 32'(tx_data), 32'hA5);
        chk("sb_e1_start", 32'(tx_start), 32'd0);
        chk("sb_e1_busy", 32'(busy), 32'd1);
        chk("sb_e1_count", 32'(count), 32'd0);
        @(negedge tx_clk);
        chk("sb_e2_start", 32'(tx_start), 32'd1);
        chk("sb_e2_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge tx_clk);
        chk("sb_wait_busy", 32'(busy), 32'd1);
        tx_done = 1'b1;
        @(negedge tx_clk);
        tx_done = 1'b0;
        chk("sb_idle_busy", 32'(busy), 32'd0);
        chk("sb_idle_start", 32'(tx_start), 32'd1);
        chk("sb_hold_data", 32'(tx_data), 32'hA5);

        stream(3, 8'h11, 4);
        stream(40, 8'h00, 2);

        // Fill / overflow; a tx_done during START must be ignored
        @(negedge tx_clk);
        wr_en   = 1'b1;
        wr_data = 8'h80;
        for (int i = 0; i < 16; i++) begin
            @(negedge tx_clk);
            wr_data = 8'h81 + 8'(i);
            tx_done = (i == 1);
        end
        @(negedge tx_clk);
        tx_done = 1'b0;
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_ovf0", 32'(overflow), 32'd0);
        chk("fill_wait", 32'(busy && tx_start), 32'd1);
        wr_data = 8'hEE;
        @(negedge tx_clk);
        chk("drop_ovf", 32'(overflow), 32'd1);
        chk("drop_count", 32'(count), 32'd16);
        ovf_clr = 1'b1;
        @(negedge tx_clk);
        wr_en = 1'b0;
        chk("clr_drop_ovf", 32'(overflow), 32'd1);
        @(negedge tx_clk);
        ovf_clr = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        wr_en   = 1'b1;
        wr_data = 8'hDD;
        tx_done = 1'b1;
        @(negedge tx_clk);
        wr_en   = 1'b0;
        tx_done = 1'b0;
        chk("fullpop_count", 32'(count), 32'd15);
        chk("fullpop_ovf", 32'(overflow), 32'd1);
        chk("fullpop_start", 32'(tx_start), 32'd0);
        chk("fullpop_data", 32'(tx_data), 32'h81);
        @(negedge tx_clk);
        wr_en   = 1'b1;
        wr_data = 8'h55;
        tx_done = 1'b1;
        @(negedge tx_clk);
        wr_en   = 1'b0;
        tx_done = 1'b0;
        chk("wrpop_count", 32'(count), 32'd15);
        chk("wrpop_start", 32'(tx_start), 32'd0);
        chk("wrpop_data", 32'(tx_data), 32'h82);
        @(negedge tx_clk);
        chk("mid_wait_busy", 32'(busy), 32'd1);

        // Asynchronous reset mid-WAIT
        resetn = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_start", 32'(tx_start), 32'd1);
        chk("arst_data", 32'(tx_data), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        @(negedge tx_clk);
        resetn = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
